cpu_bus_arb: RTL and testbench
==============================

# cpu_bus_arb

Owns the console CPU-side system bus and decides which master drives it each cycle: the 6502 core, the sprite DMA, or the APU DMC sample fetcher. DMA masters are granted only after the CPU has been halted on a read cycle. Sprite transfers are aligned to an even cycle, and DMC fetches pre-empt an in-flight sprite transfer. The block sits between the masters and the address decoder / memory map. Read data returns to all masters on the shared read bus, outside this block.

## Interface
- No parameters.
- i_clk  in  1  system clock, one bus access per cycle
- i_rstn  in  1  asynchronous, active-low reset
- i_cpu_addr  in  16  CPU address
- i_cpu_wn  in  1  CPU direction: 1 = read, 0 = write
- i_cpu_wdata  in  8  CPU write data
- o_cpu_rdy  out  1  1 = CPU may advance; 0 = CPU must hold its current cycle
- i_spr_req  in  1  sprite DMA requests the bus
- o_spr_gnt  out  1  sprite DMA owns the bus this cycle
- i_spr_addr  in  16  sprite DMA address
- i_spr_wn  in  1  sprite DMA direction
- i_spr_wdata  in  8  sprite DMA write data
- i_dmc_req  in  1  DMC requests a single sample byte
- o_dmc_gnt  out  1  DMC owns the bus this cycle; the access is always a read
- i_dmc_addr  in  16  DMC address
- o_bus_addr  out  16  muxed address
- o_bus_wn  out  1  muxed direction
- o_bus_wdata  out  8  muxed write data

## Operation
- State register holds one of five states: CPU, HALT, ALIGN, GSPR, GDMC.
- Parity bit: reset to 0, toggles every cycle unconditionally.
- Outputs are decoded from the registered state:
  - o_cpu_rdy = (state==CPU)
  - o_spr_gnt = (state==GSPR)
  - o_dmc_gnt = (state==GDMC)
- Bus mux is combinational from state and the master inputs:
  - CPU: CPU signals.
  - HALT and ALIGN: CPU address with o_bus_wn forced to 1 (dummy read), o_bus_wdata = 0.
  - GSPR: sprite signals; o_bus_wn forced to 1 when i_spr_req=0.
  - GDMC: i_dmc_addr, o_bus_wn = 1, o_bus_wdata = 0.
- Transitions:
  - CPU -> HALT when (i_spr_req | i_dmc_req) & i_cpu_wn. A CPU write cycle defers the halt, so the state stays CPU.
  - HALT (exactly 1 cycle):
    - i_dmc_req -> GDMC
    - else i_spr_req & parity==0 -> GSPR
    - else i_spr_req & parity==1 -> ALIGN
    - else -> CPU (request withdrawn)
  - ALIGN (1 cycle): i_dmc_req -> GDMC; else i_spr_req -> GSPR; else -> CPU.
  - GSPR:
    - i_dmc_req -> GDMC (pre-emption)
    - else !i_spr_req -> CPU
    - else stay
  - GDMC: a DMC grant lasts exactly 1 cycle. Next state:
    - i_spr_req -> GSPR (resumes with no re-halt and no re-alignment)
    - else -> CPU
- Priority is fixed: DMC over sprite. The CPU only gets the bus when no request is pending at a decision point.
- Sprite DMA contract:
  - It must tolerate o_spr_gnt dropping mid-transfer and hold its address and data until the grant returns.
  - It drops i_spr_req after its last access.
- A cycle in GSPR with i_spr_req=0 performs a forced read and is not an access.
- Reset, including mid-transfer: state = CPU and parity = 0. All grants read 0 and o_cpu_rdy reads 1 immediately (asynchronous). The bus shows the CPU signals.

## Timing
- Request to grant latency, from a request first sampled high in CPU with i_cpu_wn=1:
  - DMC: o_dmc_gnt high 2 cycles later (CPU -> HALT -> GDMC).
  - Sprite: 2 or 3 cycles, depending on parity.
- o_cpu_rdy falls at the first edge after the halt decision. It rises at the edge where the state returns to CPU.
- Simultaneous spr and dmc requests at the halt decision: DMC is served first, then sprite. No alignment cycle is inserted when the sprite entry comes via GDMC.
- A DMC request arriving while in CPU during a write cycle: the halt waits until i_cpu_wn=1, and there is no timeout.
- DMC request held high for multiple cycles in GDMC: each GDMC grant is one cycle, so the DMC must deassert on seeing o_dmc_gnt. If it is still high the next cycle, it is treated as a new request via CPU/GSPR.

## Test plan
- Reset with i_spr_req=1 -> o_cpu_rdy=1, grants 0, o_bus_addr = i_cpu_addr = 16'h8000.
- Sprite request at parity 0, CPU reading -> HALT, then GSPR 2 cycles after the request; 512 granted cycles with addresses 16'h0200..16'h02FF and 16'h2004 passed through; drop req -> o_cpu_rdy=1 the next cycle.
- Sprite request landing HALT on parity 1 -> exactly one ALIGN cycle with o_bus_wn=1 before the first o_spr_gnt.
- DMC request mid-sprite-transfer at i_spr_addr=16'h0280 -> o_spr_gnt=0 for one cycle; o_bus_addr = i_dmc_addr = 16'hC000, o_bus_wn=1; sprite resumes at 16'h0280.
- Request raised during a CPU write (i_cpu_wn=0 for 3 cycles) -> o_cpu_rdy stays 1 and no halt until the first read cycle.
- Assert i_rstn=0 mid-GSPR -> o_spr_gnt=0 and o_cpu_rdy=1 asynchronously; after release, state is CPU and parity is 0.

Source files
------------

// File: rtl/cpu_bus_arb_if.sv
// rtl/cpu_bus_arb_if.sv - bus master/arbiter signal bundle for cpu_bus_arb
//
// Purpose: groups the CPU, sprite DMA and DMC request/grant signals and the
//          muxed system-bus outputs so they travel as one port.
// Modports:
//   master - the requesting side (CPU core, sprite DMA, DMC fetcher):
//            drives every i_* signal, observes every o_* signal
//   slave  - the arbiter: samples every i_* signal, drives every o_* signal
// Signals:
//   i_cpu_addr[15:0], i_cpu_wn, i_cpu_wdata[7:0], o_cpu_rdy
//   i_spr_req, o_spr_gnt, i_spr_addr[15:0], i_spr_wn, i_spr_wdata[7:0]
//   i_dmc_req, o_dmc_gnt, i_dmc_addr[15:0]
//   o_bus_addr[15:0], o_bus_wn, o_bus_wdata[7:0]

interface cpu_bus_arb_if;
  logic [15:0] i_cpu_addr;
  logic        i_cpu_wn;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_rdy;

  logic        i_spr_req;
  logic        o_spr_gnt;
  logic [15:0] i_spr_addr;
  logic        i_spr_wn;
  logic [7:0]  i_spr_wdata;

  logic        i_dmc_req;
  logic        o_dmc_gnt;
  logic [15:0] i_dmc_addr;

  logic [15:0] o_bus_addr;
  logic        o_bus_wn;
  logic [7:0]  o_bus_wdata;

  modport master (
    output i_cpu_addr, i_cpu_wn, i_cpu_wdata,
    output i_spr_req, i_spr_addr, i_spr_wn, i_spr_wdata,
    output i_dmc_req, i_dmc_addr,
    input  o_cpu_rdy, o_spr_gnt, o_dmc_gnt,
    input  o_bus_addr, o_bus_wn, o_bus_wdata
  );

  modport slave (
    input  i_cpu_addr, i_cpu_wn, i_cpu_wdata,
    input  i_spr_req, i_spr_addr, i_spr_wn, i_spr_wdata,
    input  i_dmc_req, i_dmc_addr,
    output o_cpu_rdy, o_spr_gnt, o_dmc_gnt,
    output o_bus_addr, o_bus_wn, o_bus_wdata
  );
endinterface

// File: rtl/cpu_bus_arb.sv
// rtl/cpu_bus_arb.sv - CPU-side system bus arbiter (6502 / sprite DMA / DMC)
//
// Purpose: decides each cycle which master owns the CPU-side bus. DMA masters
//          are only granted after the CPU has been halted on a read cycle;
//          sprite transfers start on an even cycle; DMC fetches pre-empt an
//          in-flight sprite transfer for exactly one cycle.
// Ports:
//   i_clk   - system clock, one bus access per cycle
//   i_rstn  - asynchronous active-low reset
//   bus     - cpu_bus_arb_if.slave: master inputs, rdy/grant outputs and the
//             muxed o_bus_addr / o_bus_wn / o_bus_wdata toward the decoder

module cpu_bus_arb (
  input  logic         i_clk,
  input  logic         i_rstn,
  cpu_bus_arb_if.slave bus
);

  typedef enum logic [2:0] {
    ST_CPU   = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_GSPR  = 3'd3,
    ST_GDMC  = 3'd4
  } state_t;

  state_t state;
  // Free-running cycle parity; 0 marks an even cycle for sprite alignment.
  logic   parity;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_CPU;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        ST_CPU: begin
          // A CPU write cannot be stalled, so the halt waits for a read.
          if ((bus.i_spr_req || bus.i_dmc_req) && bus.i_cpu_wn)
            state <= ST_HALT;
        end
        ST_HALT: begin
          if (bus.i_dmc_req)
            state <= ST_GDMC;
          else if (bus.i_spr_req && !parity)
            state <= ST_GSPR;
          else if (bus.i_spr_req)
            state <= ST_ALIGN;
          else
            state <= ST_CPU;
        end
        ST_ALIGN: begin
          if (bus.i_dmc_req)
            state <= ST_GDMC;
          else if (bus.i_spr_req)
            state <= ST_GSPR;
          else
            state <= ST_CPU;
        end
        ST_GSPR: begin
          if (bus.i_dmc_req)
            state <= ST_GDMC;
          else if (!bus.i_spr_req)
            state <= ST_CPU;
        end
        ST_GDMC: begin
          // Single-cycle grant; a waiting sprite resumes without re-halting
          // or re-aligning since the CPU is still stopped.
          if (bus.i_spr_req)
            state <= ST_GSPR;
          else
            state <= ST_CPU;
        end
        default: state <= ST_CPU;
      endcase
    end
  end

  assign bus.o_cpu_rdy = (state == ST_CPU);
  assign bus.o_spr_gnt = (state == ST_GSPR);
  assign bus.o_dmc_gnt = (state == ST_GDMC);

  always_comb begin
    bus.o_bus_addr  = bus.i_cpu_addr;
    bus.o_bus_wn    = bus.i_cpu_wn;
    bus.o_bus_wdata = bus.i_cpu_wdata;
    case (state)
      ST_HALT, ST_ALIGN: begin
        // CPU is held: repeat its address as a harmless dummy read.
        bus.o_bus_addr  = bus.i_cpu_addr;
        bus.o_bus_wn    = 1'b1;
        bus.o_bus_wdata = 8'h00;
      end
      ST_GSPR: begin
        // With the request dropped the cycle degrades to a forced read.
        bus.o_bus_addr  = bus.i_spr_addr;
        bus.o_bus_wn    = bus.i_spr_req ? bus.i_spr_wn : 1'b1;
        bus.o_bus_wdata = bus.i_spr_wdata;
      end
      ST_GDMC: begin
        bus.o_bus_addr  = bus.i_dmc_addr;
        bus.o_bus_wn    = 1'b1;
        bus.o_bus_wdata = 8'h00;
      end
      default: begin
        bus.o_bus_addr  = bus.i_cpu_addr;
        bus.o_bus_wn    = bus.i_cpu_wn;
        bus.o_bus_wdata = bus.i_cpu_wdata;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// tb/tb_cpu_bus_arb.sv - self-checking bench for cpu_bus_arb

module tb_cpu_bus_arb;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b1;

  always #5 i_clk = ~i_clk;

  cpu_bus_arb_if bus ();

  cpu_bus_arb dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int dmc_seen = 0;

  logic [24:0] spr_q[$];
  logic [24:0] dmc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge; cyc counts edges out of reset.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (i_rstn) cyc++;
  endtask

  // Tick until the next edge leaves parity == p (parity after edge = cyc % 2).
  task automatic align_to(input int p);
    for (int i = 0; i < 2; i++) begin
      if (((cyc + 1) % 2) == p) break;
      tick();
    end
  endtask

  // Present sprite access k: even k reads 0x0200+k/2, odd k writes 0x2004.
  task automatic spr_present(input int k);
    bus.i_spr_addr  = (k % 2 == 0) ? 16'h0200 + 16'(k / 2) : 16'h2004;
    bus.i_spr_wn    = (k % 2 == 0);
    bus.i_spr_wdata = (k % 2 == 0) ? 8'h00 : 8'(k * 3);
    spr_q.push_back({bus.i_spr_addr, bus.i_spr_wn, bus.i_spr_wdata});
  endtask

  // Let inputs settle, then retire any granted access against the scoreboard.
  task automatic observe();
    logic [24:0] got;
    logic [24:0] exp;
    #1;
    got = {bus.o_bus_addr, bus.o_bus_wn, bus.o_bus_wdata};
    if (bus.o_dmc_gnt) begin
      dmc_seen++;
      chk("spr_gnt_during_dmc", 32'(bus.o_spr_gnt), 0);
      chk("dmc_gnt_expected", 32'(dmc_q.size() > 0), 1);
      if (dmc_q.size() > 0) begin
        exp = dmc_q.pop_front();
        chk("dmc_bus", 32'(got), 32'(exp));
      end
      bus.i_dmc_req = 1'b0;
    end
    if (bus.o_spr_gnt && bus.i_spr_req) begin
      chk("spr_gnt_expected", 32'(spr_q.size() > 0), 1);
      if (spr_q.size() > 0) begin
        exp = spr_q.pop_front();
        chk("spr_bus", 32'(got), 32'(exp));
      end
    end
  endtask

  // Run n sprite accesses from index first, holding each access until it is
  // granted; waited returns the number of ungranted cycles seen.
  task automatic spr_xfer(input int first, input int n, output int waited);
    int k;
    k = first;
    waited = 0;
    spr_present(k);
    forever begin
      observe();
      if (bus.o_spr_gnt) begin
        k++;
        if (k == first + n) break;
        tick();
        spr_present(k);
      end else begin
        waited++;
        if (waited > 4) break;
        tick();
      end
    end
    chk("spr_xfer_count", 32'(k - first), 32'(n));
  endtask

  initial begin
    int w;

    bus.i_cpu_addr  = 16'h8000;
    bus.i_cpu_wn    = 1'b1;
    bus.i_cpu_wdata = 8'h5A;
    bus.i_spr_req   = 1'b1;
    bus.i_spr_addr  = 16'h0000;
    bus.i_spr_wn    = 1'b1;
    bus.i_spr_wdata = 8'h00;
    bus.i_dmc_req   = 1'b0;
    bus.i_dmc_addr  = 16'hC000;

    // Reset with a sprite request pending: CPU owns the bus.
    #2 i_rstn = 1'b0;
    #1;
    chk("rst_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
    chk("rst_spr_gnt", 32'(bus.o_spr_gnt), 0);
    chk("rst_dmc_gnt", 32'(bus.o_dmc_gnt), 0);
    chk("rst_bus_addr", 32'(bus.o_bus_addr), 32'h8000);
    chk("rst_bus_wdata", 32'(bus.o_bus_wdata), 32'h5A);
    bus.i_spr_req = 1'b0;
    @(posedge i_clk);
    #3 i_rstn = 1'b1;
    cyc = 0;
    tick();
    chk("idle_cpu_rdy", 32'(bus.o_cpu_rdy), 1);

    // Sprite request landing HALT on parity 0: grant two cycles later.
    align_to(0);
    bus.i_spr_req = 1'b1;
    tick();
    observe();
    chk("halt0_cpu_rdy", 32'(bus.o_cpu_rdy), 0);
    chk("halt0_spr_gnt", 32'(bus.o_spr_gnt), 0);
    chk("halt0_bus_wn", 32'(bus.o_bus_wn), 1);
    chk("halt0_bus_addr", 32'(bus.o_bus_addr), 32'h8000);
    tick();
    spr_xfer(0, 512, w);
    chk("par0_wait", 32'(w), 0);
    tick();
    bus.i_spr_req = 1'b0;
    observe();
    chk("forced_read_wn", 32'(bus.o_bus_wn), 1);
    chk("forced_read_rdy", 32'(bus.o_cpu_rdy), 0);
    tick();
    chk("spr_done_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
    chk("spr_done_bus_addr", 32'(bus.o_bus_addr), 32'h8000);

    // Sprite request landing HALT on parity 1: one ALIGN dummy read.
    align_to(1);
    bus.i_spr_req = 1'b1;
    tick();
    chk("halt1_cpu_rdy", 32'(bus.o_cpu_rdy), 0);
    tick();
    observe();
    chk("align_spr_gnt", 32'(bus.o_spr_gnt), 0);
    chk("align_bus_wn", 32'(bus.o_bus_wn), 1);
    chk("align_cpu_rdy", 32'(bus.o_cpu_rdy), 0);
    tick();
    spr_xfer(254, 2, w);
    chk("align_then_gnt_wait", 32'(w), 0);

    // DMC pre-empts the transfer while the sprite waits at 0x0280.
    bus.i_dmc_req = 1'b1;
    dmc_q.push_back({16'hC000, 1'b1, 8'h00});
    tick();
    spr_xfer(256, 2, w);
    chk("preempt_wait", 32'(w), 1);
    chk("preempt_dmc_seen", 32'(dmc_seen), 1);
    tick();
    bus.i_spr_req = 1'b0;
    tick();
    chk("preempt_done_rdy", 32'(bus.o_cpu_rdy), 1);

    // DMC request during three CPU write cycles: no halt until a read.
    bus.i_cpu_addr = 16'h6000;
    bus.i_cpu_wn   = 1'b0;
    bus.i_dmc_req  = 1'b1;
    dmc_q.push_back({16'hC000, 1'b1, 8'h00});
    for (int i = 0; i < 3; i++) begin
      observe();
      chk("wr_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
      chk("wr_bus", 32'({bus.o_bus_addr, bus.o_bus_wn, bus.o_bus_wdata}),
          32'({16'h6000, 1'b0, 8'h5A}));
      tick();
    end
    bus.i_cpu_wn = 1'b1;
    observe();
    chk("wr_end_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
    tick();
    observe();
    chk("wr_halt_rdy", 32'(bus.o_cpu_rdy), 0);
    chk("wr_halt_wdata", 32'(bus.o_bus_wdata), 0);
    tick();
    observe();
    chk("wr_dmc_seen", 32'(dmc_seen), 2);
    tick();
    chk("wr_done_rdy", 32'(bus.o_cpu_rdy), 1);

    // Simultaneous DMC and sprite at a parity-1 halt: DMC first, no ALIGN.
    bus.i_cpu_addr = 16'h8000;
    align_to(1);
    bus.i_spr_req = 1'b1;
    bus.i_dmc_req = 1'b1;
    dmc_q.push_back({16'hC000, 1'b1, 8'h00});
    tick();
    tick();
    spr_xfer(0, 1, w);
    chk("simul_wait", 32'(w), 1);
    chk("simul_dmc_seen", 32'(dmc_seen), 3);
    tick();
    bus.i_spr_req = 1'b0;
    tick();
    chk("simul_done_rdy", 32'(bus.o_cpu_rdy), 1);

    // Asynchronous reset mid-GSPR while parity is 1.
    align_to(0);
    bus.i_spr_req = 1'b1;
    tick();
    tick();
    spr_xfer(0, 1, w);
    chk("pre_rst_spr_gnt", 32'(bus.o_spr_gnt), 1);
    #1 i_rstn = 1'b0;
    #1;
    chk("async_rst_spr_gnt", 32'(bus.o_spr_gnt), 0);
    chk("async_rst_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
    chk("async_rst_bus_addr", 32'(bus.o_bus_addr), 32'h8000);
    @(posedge i_clk);
    #3 i_rstn = 1'b1;
    cyc = 0;
    #1;
    chk("post_rst_cpu_rdy", 32'(bus.o_cpu_rdy), 1);
    // Parity restarts at 0, so this request halts on parity 1 and aligns.
    tick();
    chk("post_rst_halt_rdy", 32'(bus.o_cpu_rdy), 0);
    tick();
    spr_xfer(0, 1, w);
    chk("post_rst_align_wait", 32'(w), 1);
    tick();
    bus.i_spr_req = 1'b0;
    tick();
    chk("final_cpu_rdy", 32'(bus.o_cpu_rdy), 1);

    chk("spr_q_drained", 32'(spr_q.size()), 0);
    chk("dmc_q_drained", 32'(dmc_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
